// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: DrawX/DrawY pixel position with hsync, vsync, blank and sof decodes.
// Latency: one enabled vga_clk edge per pixel; every output is a flop decoded from next-state counters.
// Backpressure: pix_en low freezes the raster; every output holds until pix_en returns high.
//
// Ports:
//   vga_clk      in   pixel clock, all logic on its rising edge
//   reset        in   synchronous active-high reset, returns the raster to pixel (0,0)
//   pix_en       in   advance enable, the raster steps one pixel per edge while high
//   DrawX        out  10-bit horizontal position, 0..H_TOTAL-1
//   DrawY        out  10-bit vertical position, 0..V_TOTAL-1
//   hsync        out  horizontal sync, active-low
//   vsync        out  vertical sync, active-low, covers whole lines
//   blank        out  high while (DrawX,DrawY) is in the visible region
//   sof          out  high while (DrawX,DrawY) = (0,0)
//   frame_count  out  16-bit wrapping frame counter, present only when VGA_FRAME_COUNT_EN is defined
//
// Optional feature macro: VGA_FRAME_COUNT_EN (undefined by default; adds frame_count).
// H_TOTAL and V_TOTAL must each fit in 10 bits.

module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        vga_clk,
  input  logic        reset,
  input  logic        pix_en,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
`ifdef VGA_FRAME_COUNT_EN
  output logic        sof,
  output logic [15:0] frame_count
`else
  output logic        sof
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Decode boundaries, pre-sized to the counter width so every compare is 10-bit.
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic       at_h_last;
  logic       at_v_last;
  logic [9:0] x_nxt;
  logic [9:0] y_nxt;
  logic       hsync_nxt;
  logic       vsync_nxt;
  logic       blank_nxt;
  logic       sof_nxt;

  assign at_h_last = (DrawX == H_LAST);
  assign at_v_last = (DrawY == V_LAST);

  // Next raster position. With pix_en low the next position equals the current
  // one, so the decodes below reproduce the current outputs and everything holds.
  always_comb begin
    x_nxt = DrawX;
    y_nxt = DrawY;
    if (pix_en) begin
      if (at_h_last) begin
        x_nxt = '0;
        y_nxt = at_v_last ? '0 : DrawY + 10'd1;
      end else begin
        x_nxt = DrawX + 10'd1;
      end
    end
  end

  // Decoding from the next position lets the decodes register alongside the
  // counters, so sync/blank/sof always line up with the DrawX/DrawY shown.
  always_comb begin
    hsync_nxt = !((x_nxt >= HS_START) && (x_nxt < HS_END));
    vsync_nxt = !((y_nxt >= VS_START) && (y_nxt < VS_END));
    blank_nxt = (x_nxt < H_VIS) && (y_nxt < V_VIS);
    sof_nxt   = (x_nxt == 10'd0) && (y_nxt == 10'd0);
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      DrawX <= '0;
      DrawY <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
      blank <= 1'b1;
      sof   <= 1'b1;
    end else begin
      DrawX <= x_nxt;
      DrawY <= y_nxt;
      hsync <= hsync_nxt;
      vsync <= vsync_nxt;
      blank <= blank_nxt;
      sof   <= sof_nxt;
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  // Counts the enabled edge that wraps the last pixel of a frame back to (0,0).
  logic frame_wrap;

  assign frame_wrap = pix_en && at_h_last && at_v_last;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      frame_count <= '0;
    end else if (frame_wrap) begin
      frame_count <= frame_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: a default-size instance for line-level checks and a
// small-raster instance for frame-level, frame_count and randomized checks.
// The reference model tracks a linear pixel index and derives every output from it.

module tb_vga_timing_gen;

  // Default 640x480 geometry.
  localparam int B_HA = 640, B_HF = 16, B_HS = 96, B_HB = 48;
  localparam int B_VA = 480, B_VF = 10, B_VS = 2,  B_VB = 33;
  localparam int B_HT = B_HA + B_HF + B_HS + B_HB;
  localparam int B_TOT = B_HT * (B_VA + B_VF + B_VS + B_VB);

  // Small geometry so whole frames fit in a short run: 15 x 13 = 195 pixels.
  localparam int S_HA = 8, S_HF = 2, S_HS = 3, S_HB = 2;
  localparam int S_VA = 6, S_VF = 2, S_VS = 2, S_VB = 3;
  localparam int S_HT = S_HA + S_HF + S_HS + S_HB;
  localparam int S_TOT = S_HT * (S_VA + S_VF + S_VS + S_VB);

  logic vga_clk = 1'b0;
  always #20 vga_clk = ~vga_clk;

  logic       b_reset = 1'b1, b_pix_en = 1'b0;
  logic [9:0] b_x, b_y;
  logic       b_hs, b_vs, b_bl, b_sof;
  logic       s_reset = 1'b1, s_pix_en = 1'b0;
  logic [9:0] s_x, s_y;
  logic       s_hs, s_vs, s_bl, s_sof;
`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] b_fc, s_fc;
`endif

  logic [23:0] b_obs, s_obs;
  assign b_obs = {b_x, b_y, b_hs, b_vs, b_bl, b_sof};
  assign s_obs = {s_x, s_y, s_hs, s_vs, s_bl, s_sof};

  vga_timing_gen u_big (
    .vga_clk(vga_clk), .reset(b_reset), .pix_en(b_pix_en),
    .DrawX(b_x), .DrawY(b_y), .hsync(b_hs), .vsync(b_vs), .blank(b_bl),
`ifdef VGA_FRAME_COUNT_EN
    .sof(b_sof), .frame_count(b_fc)
`else
    .sof(b_sof)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB)
  ) u_small (
    .vga_clk(vga_clk), .reset(s_reset), .pix_en(s_pix_en),
    .DrawX(s_x), .DrawY(s_y), .hsync(s_hs), .vsync(s_vs), .blank(s_bl),
`ifdef VGA_FRAME_COUNT_EN
    .sof(s_sof), .frame_count(s_fc)
`else
    .sof(s_sof)
`endif
  );

  int checks = 0;
  int errors = 0;
  int bp = 0;     // model pixel index of u_big
  int sp = 0;     // model pixel index of u_small
  int sfc = 0;    // model frame count of u_small

  // Expected {DrawX, DrawY, hsync, vsync, blank, sof} for linear pixel index p.
  function automatic logic [23:0] ref_out(input int p, input int ha, input int hf, input int hs,
                                          input int hb, input int va, input int vf, input int vs);
    int ht, x, y;
    logic h, v, bl, sf;
    ht = ha + hf + hs + hb;
    x  = p % ht;
    y  = p / ht;
    h  = !(x >= ha + hf && x < ha + hf + hs);
    v  = !(y >= va + vf && y < va + vf + vs);
    bl = (x < ha) && (y < va);
    sf = (p == 0);
    return {x[9:0], y[9:0], h, v, bl, sf};
  endfunction

  function automatic logic [23:0] ref_b(input int p);
    return ref_out(p, B_HA, B_HF, B_HS, B_HB, B_VA, B_VF, B_VS);
  endfunction

  function automatic logic [23:0] ref_s(input int p);
    return ref_out(p, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS);
  endfunction

  // Inputs change on the falling edge, the DUT samples on the rising edge,
  // outputs are observed on the following falling edge.
  task automatic tick_b(input logic rst, input logic en);
    b_reset = rst; b_pix_en = en;
    @(posedge vga_clk);
    if (rst) bp = 0;
    else if (en) bp = (bp + 1) % B_TOT;
    @(negedge vga_clk);
  endtask

  task automatic tick_s(input logic rst, input logic en);
    s_reset = rst; s_pix_en = en;
    @(posedge vga_clk);
    if (rst) begin
      sp = 0; sfc = 0;
    end else if (en) begin
      if (sp == S_TOT - 1) sfc = (sfc + 1) % 65536;
      sp = (sp + 1) % S_TOT;
    end
    @(negedge vga_clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick_b(1'b1, 1'b1);
      tick_s(1'b1, 1'b1);
      checks++;
      if (b_obs !== 24'({10'd0, 10'd0, 4'b1111})) begin
        errors++;
        $display("FAIL reset_big obs=%h exp=%h", b_obs, 24'({10'd0, 10'd0, 4'b1111}));
      end
      checks++;
      if (s_obs !== ref_s(0)) begin
        errors++;
        $display("FAIL reset_small obs=%h exp=%h", s_obs, ref_s(0));
      end
`ifdef VGA_FRAME_COUNT_EN
      checks++;
      if (b_fc !== 16'd0) begin
        errors++;
        $display("FAIL reset_frame_count obs=%0d exp=0", b_fc);
      end
`endif
    end
    b_reset = 1'b0;
    s_reset = 1'b0;
  endtask

  task automatic test_first_line();
    for (int i = 0; i < B_HT; i++) begin
      checks++;
      if (b_x !== 10'(i) || b_y !== 10'd0 || b_obs !== ref_b(bp)) begin
        errors++;
        $display("FAIL first_line i=%0d obs=%h exp=%h", i, b_obs, ref_b(bp));
      end
      tick_b(1'b0, 1'b1);
    end
    checks++;
    if (b_x !== 10'd0 || b_y !== 10'd1 || b_sof !== 1'b0) begin
      errors++;
      $display("FAIL line_wrap obs=(%0d,%0d) sof=%b exp=(0,1) sof=0", b_x, b_y, b_sof);
    end
  endtask

  task automatic test_line_sync();
    int hs_cnt = 0, hs_first = -1, hs_last = -1, bl_cnt = 0, bl_first = -1;
    for (int i = 0; i < B_HT; i++) begin
      checks++;
      if (b_obs !== ref_b(bp)) begin
        errors++;
        $display("FAIL line_sync_px obs=%h exp=%h", b_obs, ref_b(bp));
      end
      if (!b_hs) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(b_x);
        hs_last = int'(b_x);
      end
      if (!b_bl) begin
        bl_cnt++;
        if (bl_first < 0) bl_first = int'(b_x);
      end
      tick_b(1'b0, 1'b1);
    end
    checks++;
    if (hs_cnt != 96 || hs_first != 656 || hs_last != 751) begin
      errors++;
      $display("FAIL hsync_window cnt=%0d first=%0d last=%0d exp 96/656/751", hs_cnt, hs_first, hs_last);
    end
    checks++;
    if (bl_cnt != 160 || bl_first != 640) begin
      errors++;
      $display("FAIL blank_window cnt=%0d first=%0d exp 160/640", bl_cnt, bl_first);
    end
  endtask

  task automatic test_hold();
    while (bp != 5 * B_HT + 100) tick_b(1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick_b(1'b0, 1'b0);
      checks++;
      if (b_x !== 10'd100 || b_y !== 10'd5 || b_obs !== ref_b(bp)) begin
        errors++;
        $display("FAIL hold i=%0d obs=%h exp=%h", i, b_obs, ref_b(bp));
      end
    end
    tick_b(1'b0, 1'b1);
    checks++;
    if (b_x !== 10'd101 || b_y !== 10'd5) begin
      errors++;
      $display("FAIL resume obs=(%0d,%0d) exp=(101,5)", b_x, b_y);
    end
  endtask

  task automatic test_mid_reset();
    while (bp != 5 * B_HT + 300) tick_b(1'b0, 1'b1);
    tick_b(1'b1, 1'b0);
    checks++;
    if (b_obs !== 24'({10'd0, 10'd0, 4'b1111})) begin
      errors++;
      $display("FAIL mid_reset obs=%h exp=%h", b_obs, 24'({10'd0, 10'd0, 4'b1111}));
    end
    tick_b(1'b0, 1'b1);
    checks++;
    if (b_x !== 10'd1 || b_y !== 10'd0 || b_sof !== 1'b0) begin
      errors++;
      $display("FAIL after_reset obs=(%0d,%0d) sof=%b exp=(1,0) sof=0", b_x, b_y, b_sof);
    end
  endtask

  task automatic test_full_frame();
    int vs_cnt = 0, bl_cnt = 0, last_sof = -1, gap_bad = 0, sof_seen = 0;
    tick_s(1'b1, 1'b0);
    s_reset = 1'b0;
    for (int i = 0; i < 2 * S_TOT + 1; i++) begin
      checks++;
      if (s_obs !== ref_s(sp)) begin
        errors++;
        $display("FAIL frame_px i=%0d obs=%h exp=%h", i, s_obs, ref_s(sp));
      end
      if (i < S_TOT) begin
        if (!s_vs) vs_cnt++;
        if (s_bl) bl_cnt++;
      end
      if (s_sof) begin
        sof_seen++;
        if (last_sof >= 0 && i - last_sof != S_TOT) gap_bad++;
        last_sof = i;
      end
      tick_s(1'b0, 1'b1);
    end
    checks++;
    if (vs_cnt != S_HT * S_VS || bl_cnt != S_HA * S_VA) begin
      errors++;
      $display("FAIL frame_counts vsync_low=%0d blank=%0d exp %0d/%0d", vs_cnt, bl_cnt, S_HT * S_VS, S_HA * S_VA);
    end
    checks++;
    if (sof_seen != 3 || gap_bad != 0) begin
      errors++;
      $display("FAIL sof_period seen=%0d bad_gaps=%0d exp 3/0", sof_seen, gap_bad);
    end
  endtask

`ifdef VGA_FRAME_COUNT_EN
  task automatic test_frame_count();
    int k = 0;
    tick_s(1'b1, 1'b0);
    s_reset = 1'b0;
    for (int i = 0; i < 3 * S_TOT + 1; i++) begin
      if (s_sof) begin
        checks++;
        if (s_fc !== 16'(k)) begin
          errors++;
          $display("FAIL frame_count_sof obs=%0d exp=%0d", s_fc, k);
        end
        k++;
      end
      tick_s(1'b0, 1'b1);
    end
    tick_s(1'b1, 1'b1);
    checks++;
    if (s_fc !== 16'd0) begin
      errors++;
      $display("FAIL frame_count_reset obs=%0d exp=0", s_fc);
    end
    s_reset = 1'b0;
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      tick_s($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0);
      checks++;
      if (s_obs !== ref_s(sp)) begin
        errors++;
        $display("FAIL random i=%0d obs=%h exp=%h", i, s_obs, ref_s(sp));
      end
`ifdef VGA_FRAME_COUNT_EN
      checks++;
      if (s_fc !== 16'(sfc)) begin
        errors++;
        $display("FAIL random_fc i=%0d obs=%0d exp=%0d", i, s_fc, sfc);
      end
`endif
    end
  endtask

  initial begin
    @(negedge vga_clk);
    test_reset();
    test_first_line();
    test_line_sync();
    test_hold();
    test_mid_reset();
    test_full_frame();
`ifdef VGA_FRAME_COUNT_EN
    test_frame_count();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
